// File: rtl/spi_slave_rx_multi.sv
// spi_slave_rx_multi
//   SPI slave receiver with 1/2/4 MOSI lanes and P_WORD_W-bit word assembly.
//   It oversamples the SPI pins in the clk domain and delivers words on a
//   valid/ready stream together with frame and error status.
//   Build option: define SPI_RX_FIFO_EN to put a P_FIFO_DEPTH-entry FIFO in
//   front of m_*. With the macro undefined, a single holding register is used.
// Ports
//   clk, rst_n     system clock (>= 4x SCLK), asynchronous active-low reset
//   spi_sclk       SPI clock (async)
//   spi_cs_n       SPI chip select, active low (async)
//   spi_mosi       P_LANES data lanes (async)
//   m_data/m_valid received word stream; a word is taken when m_valid & m_ready
//   m_ready        downstream ready
//   frame_active   synchronised chip select is asserted
//   frame_end      1-clk pulse when the synchronised chip select deasserts
//   partial_err    sticky: frame closed mid-word; cleared at the next frame start
//   overrun        sticky: a word was dropped because storage was full
//   word_cnt       words completed in the current frame
module spi_slave_rx_multi #(
  parameter int unsigned P_LANES      = 1,
  parameter int unsigned P_WORD_W     = 8,
  parameter int unsigned P_CPOL       = 0,
  parameter int unsigned P_CPHA       = 0,
  parameter int unsigned P_MSB_FIRST  = 1,
  parameter int unsigned P_SYNC       = 2,
  parameter int unsigned P_FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                spi_sclk,
  input  logic                spi_cs_n,
  input  logic [P_LANES-1:0]  spi_mosi,
  output logic [P_WORD_W-1:0] m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                frame_active,
  output logic                frame_end,
  output logic                partial_err,
  output logic                overrun,
  output logic [15:0]         word_cnt
);

  localparam int unsigned    BCW         = $clog2(P_WORD_W + 1);
  localparam logic [BCW-1:0] LAST_CNT    = BCW'(P_WORD_W - P_LANES);
  localparam logic [BCW-1:0] LANE_INC    = BCW'(P_LANES);
  localparam logic           CPOL_B      = 1'(P_CPOL);
  localparam logic           SAMPLE_RISE = (P_CPOL == P_CPHA);

  if ((P_LANES != 1 && P_LANES != 2 && P_LANES != 4) || (P_WORD_W % P_LANES) != 0 ||
      P_WORD_W < 8 || P_WORD_W > 32 || P_SYNC < 2 ||
      P_FIFO_DEPTH < 2 || (P_FIFO_DEPTH & (P_FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("spi_slave_rx_multi: illegal parameter combination");
  end

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  // ---------------- input synchronisers ----------------
  logic [P_SYNC-1:0]              sclk_sync;
  logic [P_SYNC-1:0]              cs_sync;
  logic [P_SYNC-1:0][P_LANES-1:0] mosi_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= {P_SYNC{CPOL_B}};
      cs_sync   <= '1;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[P_SYNC-2:0], spi_sclk};
      cs_sync   <= {cs_sync[P_SYNC-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[P_SYNC-2:0], spi_mosi};
    end
  end

  // Edges are seen between the last two stages; the data lanes are taken from
  // the last stage, i.e. the value present just before the sampling edge.
  logic               sclk_rise, sclk_fall, sample_edge, cs_fall, cs_rise;
  logic [P_LANES-1:0] lanes;

  assign sclk_rise   =  sclk_sync[P_SYNC-2] & ~sclk_sync[P_SYNC-1];
  assign sclk_fall   = ~sclk_sync[P_SYNC-2] &  sclk_sync[P_SYNC-1];
  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign cs_fall     = ~cs_sync[P_SYNC-2] &  cs_sync[P_SYNC-1];
  assign cs_rise     =  cs_sync[P_SYNC-2] & ~cs_sync[P_SYNC-1];
  assign lanes       = mosi_sync[P_SYNC-1];

  // ---------------- word assembler ----------------
  logic [P_WORD_W-1:0] shift_q, shift_nxt;

  always_comb begin
    if (P_MSB_FIRST != 0) shift_nxt = {shift_q[P_WORD_W-P_LANES-1:0], lanes};
    else                  shift_nxt = {lanes, shift_q[P_WORD_W-1:P_LANES]};
  end

  // ---------------- frame FSM ----------------
  state_t         state, state_nxt;
  logic [BCW-1:0] bit_cnt, bit_cnt_nxt, cnt_adv;
  logic           do_start, do_shift, do_word, do_close, set_partial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // A final sample edge coinciding with CS rise completes the word before the
  // frame closes, so the error check looks at the count after this clk's shift.
  always_comb begin
    state_nxt   = state;
    do_start    = 1'b0;
    do_shift    = 1'b0;
    do_word     = 1'b0;
    do_close    = 1'b0;
    set_partial = 1'b0;
    cnt_adv     = bit_cnt;
    bit_cnt_nxt = bit_cnt;
    case (state)
      ST_IDLE: begin
        if (cs_fall) begin
          state_nxt   = ST_SHIFT;
          do_start    = 1'b1;
          bit_cnt_nxt = '0;
        end
      end
      ST_SHIFT: begin
        if (sample_edge) begin
          do_shift = 1'b1;
          if (bit_cnt == LAST_CNT) begin
            do_word = 1'b1;
            cnt_adv = '0;
          end else begin
            cnt_adv = bit_cnt + LANE_INC;
          end
        end
        bit_cnt_nxt = cnt_adv;
        if (cs_rise) begin
          state_nxt   = ST_IDLE;
          do_close    = 1'b1;
          set_partial = (cnt_adv != '0);
          bit_cnt_nxt = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign frame_active = (state == ST_SHIFT);

  logic word_done;
  logic store_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      shift_q     <= '0;
      word_done   <= 1'b0;
      frame_end   <= 1'b0;
      word_cnt    <= '0;
      partial_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      bit_cnt   <= bit_cnt_nxt;
      word_done <= do_word;
      frame_end <= do_close;
      if (do_shift) shift_q <= shift_nxt;
      if (do_start)     word_cnt <= '0;
      else if (do_word) word_cnt <= word_cnt + 16'd1;
      if (do_start)         partial_err <= 1'b0;
      else if (set_partial) partial_err <= 1'b1;
      if (do_start)                      overrun <= 1'b0;
      else if (word_done && store_full)  overrun <= 1'b1;
    end
  end

  // ---------------- output storage ----------------
`ifdef SPI_RX_FIFO_EN
  localparam int unsigned AW = $clog2(P_FIFO_DEPTH);

  logic [P_WORD_W-1:0] fifo_mem [P_FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         fifo_cnt, remain;
  logic                push, pop;

  assign store_full = (fifo_cnt == (AW+1)'(P_FIFO_DEPTH));
  assign push       = word_done & ~store_full;
  assign pop        = m_valid & m_ready;
  assign remain     = fifo_cnt - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= shift_q;
  end

  // m_* is a registered copy of the head entry, refreshed from the post-pop
  // pointer; it only reloads when an entry remains, so it is stable while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_cnt <= remain + (AW+1)'(push);
      m_valid  <= (remain != '0);
      if (remain != '0) m_data <= fifo_mem[rd_ptr + AW'(pop)];
    end
  end
`else
  assign store_full = m_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (word_done && !m_valid) begin
      m_valid <= 1'b1;
      m_data  <= shift_q;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end
`endif

endmodule
